dmem_host_ctrl: RTL and testbench
=================================

# dmem_host_ctrl

Synthesizable host-side controller for the data memory port of `top`. It accepts a stream of matrix words and writes them into data memory through the testbench-address path. It then pulses core reset and start, waits for `END`, and streams a result window back out of data memory. It sits between an external link (UART/FIFO) and `top`'s `addr_mux_select` / `current_addr` / `write_from_tb` / `mem_data` / `ar_in` / `dmem_out_disp` pins, so a board can run without a simulation bench.

## Interface
Parameters:
- `ADDR_W`, 16, data memory address width
- `DATA_W`, 16, data word width
- `LOAD_WORDS`, 1000, words written at addresses 0..LOAD_WORDS-1
- `DUMP_WORDS`, 997, words read back from addresses 0..DUMP_WORDS-1

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `RESET` in 1: asynchronous, active-high
- `go` in 1: starts a session; sampled only in IDLE
- `in_data` in DATA_W: load-stream word
- `in_valid` in 1: load-stream valid
- `in_ready` out 1: load-stream ready
- `out_data` out DATA_W: dump-stream word
- `out_valid` out 1: dump-stream valid
- `out_ready` in 1: dump-stream ready
- `addr_mux_select` out 2: 0 = cores, 1 = host write, 2 = host read
- `dmem_addr` out ADDR_W: drives `current_addr` and `ar_in`
- `dmem_wdata` out DATA_W: drives `mem_data`
- `dmem_we` out 1: drives `write_from_tb`
- `dmem_rdata` in DATA_W: from `dmem_out_disp`; valid 1 cycle after `dmem_addr` changes
- `core_reset` out 1, `core_start` out 1, `core_end` in 1: to and from `top` `RESET` / `START` / `END`
- `busy` out 1, `done` out 1, `mult_cycles` out 32

## Operation
- States: IDLE, LOAD, CRST, CGAP, CSTART, WAIT_END, RD_ADDR, RD_WAIT, RD_OUT, DONE.
- IDLE: `go`=1 moves to LOAD, clears `done`, clears `mult_cycles`, zeroes the word counter.
  - If LOAD_WORDS=0, go directly to CRST.
- LOAD: `addr_mux_select`=1 and `in_ready`=1.
  - On each `in_valid & in_ready`, the next cycle drives `dmem_addr`=counter, `dmem_wdata`=`in_data`, `dmem_we`=1 for exactly 1 cycle, then increments the counter.
  - After the handshake for word LOAD_WORDS-1, drop `in_ready` and move to CRST once that write cycle completes.
- CRST: `addr_mux_select`=0 and `core_reset`=1 for 2 cycles.
- CGAP: all core controls low for 2 cycles.
- CSTART: `core_start`=1 for exactly 1 cycle. `mult_cycles` starts counting in this cycle.
- WAIT_END: `mult_cycles` increments every cycle, saturating at 2^32-1.
  - `core_end`=1 stops the count (that cycle included), zeroes the counter, and moves to RD_ADDR.
  - If DUMP_WORDS=0, go to DONE instead.
  - `core_end` is ignored in every other state. There is no timeout.
- RD_ADDR: `addr_mux_select`=2, `dmem_addr`=counter.
- RD_WAIT: one cycle for read latency.
- RD_OUT: capture `dmem_rdata` into `out_data` and assert `out_valid`. Hold both stable until `out_ready`.
  - On handshake, increment the counter.
  - Go to RD_ADDR if counter < DUMP_WORDS, else DONE.
- DONE: `addr_mux_select`=0 and `done`=1. `done` holds until the next `go` accepted in IDLE. The FSM returns to IDLE on the next cycle.
- `busy`=1 in every state except IDLE.
  - `go` while busy is ignored.
  - `in_valid` outside LOAD is ignored; `in_ready` stays 0.
- Counters are ADDR_W wide and never wrap within a session.

## Timing
- Reset values: every output is 0, including `addr_mux_select`=0 (cores own memory), `in_ready`=0, `out_valid`=0, `dmem_we`=0, `mult_cycles`=0, `done`=0. State is IDLE.
- `RESET` mid-session takes effect immediately (asynchronous).
  - All outputs return to reset values and a partial load or dump is abandoned.
  - `top` is not reset by this block; its own reset is asserted only via `core_reset`.
- Load throughput: 1 word per cycle with `in_valid` held high. The `dmem_we` pulse lags its handshake by 1 cycle.
- `go` to first `in_ready`: 1 cycle.
- Last load write to `core_start`: 5 cycles (2 CRST + 2 CGAP + 1).
- Dump throughput: 1 word per 3 cycles minimum (RD_ADDR, RD_WAIT, RD_OUT with `out_ready`=1).
- `out_ready` held low stalls the dump indefinitely, with `out_data` stable.
- All outputs are registered except `in_ready`, which is decoded from state.

## Test plan
- Reset with LOAD_WORDS=4, DUMP_WORDS=4: assert `RESET` -> all outputs 0 and `addr_mux_select`=0. `go` -> stream 10, 20, 30, 40 -> `dmem_we` pulses at addresses 0..3 with matching data, 1 cycle after each handshake.
- Core sequencing: after load -> `core_reset` high 2 cycles, low 2, `core_start` high 1. Bench raises `core_end` 7 cycles after `core_start` -> `mult_cycles`=8.
- Dump with a memory model preloaded 0xA0..0xA3 and `out_ready`=1 -> `out_data` sequence 0xA0, 0xA1, 0xA2, 0xA3, one word every 3 cycles, `addr_mux_select`=2. Then `done`=1 and `addr_mux_select`=0.
- Backpressure: `out_ready`=0 for 10 cycles on word 1 -> `out_data` and `out_valid` held stable, no address advance. Load gaps with `in_valid` toggling -> no extra or missing writes.
- Spurious inputs: `core_end` high during LOAD, and `go` pulsed during WAIT_END -> both ignored, with the session result unchanged.
- Asynchronous reset mid-LOAD after 2 words -> outputs 0 without waiting for a clock edge. A new `go` reloads from address 0.

Source files
------------

// File: rtl/dmem_host_ctrl_if.sv
// Bundle of streams, memory-port and core-control signals between dmem_host_ctrl
// (master side) and its surroundings (slave side).
interface dmem_host_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              go;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        addr_mux_select;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_rdata;
  logic              core_reset;
  logic              core_start;
  logic              core_end;
  logic              busy;
  logic              done;
  logic [31:0]       mult_cycles;
  logic [3:0]        state_dbg;

  modport master (
    input  go, in_data, in_valid, out_ready, dmem_rdata, core_end,
    output in_ready, out_data, out_valid, addr_mux_select, dmem_addr,
           dmem_wdata, dmem_we, core_reset, core_start, busy, done,
           mult_cycles, state_dbg
  );

  modport slave (
    output go, in_data, in_valid, out_ready, dmem_rdata, core_end,
    input  in_ready, out_data, out_valid, addr_mux_select, dmem_addr,
           dmem_wdata, dmem_we, core_reset, core_start, busy, done,
           mult_cycles, state_dbg
  );
endinterface

// File: rtl/dmem_host_ctrl.sv
// Host-side controller for top's data memory port: loads a word stream into
// dmem, pulses core reset/start, times the run, then dumps a result window.
module dmem_host_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LOAD_WORDS = 1000,
  parameter int DUMP_WORDS = 997
) (
  input  logic             clk,
  input  logic             RESET,
  dmem_host_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_CRST     = 4'd2;
  localparam logic [3:0] S_CGAP     = 4'd3;
  localparam logic [3:0] S_CSTART   = 4'd4;
  localparam logic [3:0] S_WAIT_END = 4'd5;
  localparam logic [3:0] S_RD_ADDR  = 4'd6;
  localparam logic [3:0] S_RD_WAIT  = 4'd7;
  localparam logic [3:0] S_RD_OUT   = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(LOAD_WORDS - 1);
  localparam logic [ADDR_W:0]   DUMP_N    = (ADDR_W + 1)'(DUMP_WORDS);

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic              phase_q, phase_d;
  logic              load_fin_q, load_fin_d;
  logic [1:0]        mux_q, mux_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              core_reset_q, core_reset_d;
  logic              core_start_q, core_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       mult_q, mult_d, mult_inc;
  logic              in_rdy;

  // Both streams use valid/ready: a word moves on a rising edge where valid and
  // ready are both high; a source holds valid and data stable until then.
  // in_ready drops as soon as the final load word is taken.
  assign in_rdy   = (state_q == S_LOAD) && !load_fin_q;
  assign cnt_inc  = cnt_q + ADDR_W'(1);
  assign mult_inc = (mult_q == 32'hFFFF_FFFF) ? mult_q : mult_q + 32'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = 1'b0;
    load_fin_d = load_fin_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    out_data_d = out_data_q;
    done_d     = done_q;
    mult_d     = mult_q;

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          done_d     = 1'b0;
          mult_d     = '0;
          cnt_d      = '0;
          load_fin_d = 1'b0;
          state_d    = (LOAD_WORDS == 0) ? S_CRST : S_LOAD;
        end
      end
      S_LOAD: begin
        // The last write is still on the bus this cycle; leave once it lands.
        if (load_fin_q) begin
          load_fin_d = 1'b0;
          state_d    = S_CRST;
        end else if (bus.in_valid) begin
          addr_d  = cnt_q;
          wdata_d = bus.in_data;
          we_d    = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_q == LOAD_LAST) load_fin_d = 1'b1;
        end
      end
      S_CRST: begin
        if (phase_q) state_d = S_CGAP;
        else         phase_d = 1'b1;
      end
      S_CGAP: begin
        if (phase_q) state_d = S_CSTART;
        else         phase_d = 1'b1;
      end
      S_CSTART: begin
        mult_d  = mult_inc;
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        mult_d = mult_inc;
        if (bus.core_end) begin
          cnt_d   = '0;
          state_d = (DUMP_WORDS == 0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        out_data_d = bus.dmem_rdata;
        state_d    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_inc;
          state_d = ({1'b0, cnt_inc} < DUMP_N) ? S_RD_ADDR : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    if (state_d == S_RD_ADDR) addr_d = cnt_d;
    if (state_d == S_DONE)    done_d = 1'b1;
    case (state_d)
      S_LOAD:                        mux_d = 2'd1;
      S_RD_ADDR, S_RD_WAIT, S_RD_OUT: mux_d = 2'd2;
      default:                       mux_d = 2'd0;
    endcase
    out_valid_d  = (state_d == S_RD_OUT);
    core_reset_d = (state_d == S_CRST);
    core_start_d = (state_d == S_CSTART);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      load_fin_q   <= 1'b0;
      mux_q        <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      core_reset_q <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mult_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      load_fin_q   <= load_fin_d;
      mux_q        <= mux_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mult_q       <= mult_d;
    end
  end

  assign bus.in_ready        = in_rdy;
  assign bus.out_data        = out_data_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.addr_mux_select = mux_q;
  assign bus.dmem_addr       = addr_q;
  assign bus.dmem_wdata      = wdata_q;
  assign bus.dmem_we         = we_q;
  assign bus.core_reset      = core_reset_q;
  assign bus.core_start      = core_start_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.mult_cycles     = mult_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_dmem_host_ctrl.sv
// Bench for dmem_host_ctrl: a memory model plus a stand-in core, driven by a
// table of sessions, random sessions and an asynchronous mid-load reset.
module tb_dmem_host_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NL = 4;
  localparam int ND = 4;

  typedef struct packed {
    logic [NL-1:0][DW-1:0] ld;
    logic [ND-1:0][DW-1:0] res;
    int                    lat;
    int                    gap_pct;
    int                    stall_word;
    int                    stall_cyc;
    bit                    spur;
    logic [31:0]           exp_mult;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;
  logic [DW-1:0] mem [0:15];
  logic core_load = 1'b0;
  logic [ND-1:0][DW-1:0] core_buf;
  logic [DW-1:0] exp_q[$];
  vec_t tbl [3];

  dmem_host_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

  dmem_host_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .LOAD_WORDS(NL), .DUMP_WORDS(ND)
  ) dut (
    .clk  (clk),
    .RESET(rst),
    .bus  (dif.master)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Data memory of top: host writes only land with mux=1, reads return junk unless mux=2.
  always @(posedge clk) begin
    if (dif.dmem_we) wr_count <= wr_count + 1;
    if (dif.dmem_we && dif.addr_mux_select == 2'd1) mem[dif.dmem_addr[3:0]] <= dif.dmem_wdata;
    if (core_load) for (int i = 0; i < ND; i++) mem[i] <= core_buf[i];
    dif.dmem_rdata <= (dif.addr_mux_select == 2'd2) ? mem[dif.dmem_addr[3:0]] : 16'hDEAD;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"},    dif.in_ready, 0);
    chk({tag, "_out_valid"},   dif.out_valid, 0);
    chk({tag, "_out_data"},    dif.out_data, 0);
    chk({tag, "_mux"},         dif.addr_mux_select, 0);
    chk({tag, "_dmem_addr"},   dif.dmem_addr, 0);
    chk({tag, "_dmem_wdata"},  dif.dmem_wdata, 0);
    chk({tag, "_dmem_we"},     dif.dmem_we, 0);
    chk({tag, "_core_reset"},  dif.core_reset, 0);
    chk({tag, "_core_start"},  dif.core_start, 0);
    chk({tag, "_busy"},        dif.busy, 0);
    chk({tag, "_done"},        dif.done, 0);
    chk({tag, "_mult_cycles"}, dif.mult_cycles, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_go();
    @(negedge clk);
    chk("idle_in_ready", dif.in_ready, 0);
    chk("idle_busy", dif.busy, 0);
    dif.go = 1'b1;
    @(negedge clk);
    dif.go = 1'b0;
    chk("go_in_ready", dif.in_ready, 1);
    chk("go_busy", dif.busy, 1);
    chk("go_done_clr", dif.done, 0);
    chk("go_mult_clr", dif.mult_cycles, 0);
    chk("go_mux", dif.addr_mux_select, 1);
  endtask

  task automatic do_load(input logic [NL-1:0][DW-1:0] w, input int n, input int gap_pct,
                         input bit spur);
    int i = 0;
    int tmo = 0;
    bit pend = 0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    while ((i < n || pend) && tmo < 400) begin
      @(negedge clk);
      tmo++;
      dif.core_end = spur && ($urandom_range(0, 1) == 1);
      if (pend) begin
        chk("load_we", dif.dmem_we, 1);
        chk("load_addr", dif.dmem_addr, pa);
        chk("load_wdata", dif.dmem_wdata, pd);
        chk("load_mux", dif.addr_mux_select, 1);
        if (i == NL) chk("load_ready_drop", dif.in_ready, 0);
        pend = 0;
      end else begin
        chk("load_no_we", dif.dmem_we, 0);
      end
      if (i < n && $urandom_range(0, 99) >= gap_pct) begin
        dif.in_valid = 1'b1;
        dif.in_data  = w[i];
        if (dif.in_ready) begin
          pend = 1;
          pa   = AW'(i);
          pd   = w[i];
          i++;
        end
      end else begin
        dif.in_valid = 1'b0;
        dif.in_data  = DW'($urandom);
      end
    end
    dif.in_valid = 1'b0;
    dif.core_end = 1'b0;
    chk("load_complete", i, n);
  endtask

  task automatic do_core(input logic [NL-1:0][DW-1:0] ld, input logic [ND-1:0][DW-1:0] res,
                         input int lat, input bit spur_go, input logic [31:0] exp_mult);
    @(negedge clk);
    for (int i = 0; i < NL; i++) chk("mem_after_load", mem[i], ld[i]);
    chk("crst0_reset", dif.core_reset, 1);
    chk("crst0_mux", dif.addr_mux_select, 0);
    chk("crst0_start", dif.core_start, 0);
    @(negedge clk);
    chk("crst1_reset", dif.core_reset, 1);
    @(negedge clk);
    chk("cgap0_reset", dif.core_reset, 0);
    chk("cgap0_start", dif.core_start, 0);
    @(negedge clk);
    chk("cgap1_reset", dif.core_reset, 0);
    chk("cgap1_start", dif.core_start, 0);
    @(negedge clk);
    chk("cstart_start", dif.core_start, 1);
    chk("cstart_busy", dif.busy, 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("start_width", dif.core_start, 0);
        core_buf  = res;
        core_load = 1'b1;
      end else begin
        core_load = 1'b0;
      end
      dif.go       = spur_go && (k == 1);
      dif.core_end = (k == lat);
    end
    @(negedge clk);
    dif.core_end = 1'b0;
    dif.go       = 1'b0;
    core_load    = 1'b0;
    chk("mult_cycles", dif.mult_cycles, exp_mult);
    chk("run_busy", dif.busy, 1);
  endtask

  task automatic do_dump(input logic [ND-1:0][DW-1:0] res, input int stall_word,
                         input int stall_cyc, input logic [31:0] exp_mult);
    int k = 0;
    int tmo = 0;
    int neg = 0;
    int last = -1;
    int held = 0;
    logic [DW-1:0] e;
    for (int i = 0; i < ND; i++) exp_q.push_back(res[i]);
    dif.out_ready = 1'b1;
    while (k < ND && tmo < 300) begin
      @(negedge clk);
      neg++;
      tmo++;
      if (dif.out_valid) begin
        e = exp_q[0];
        chk("dump_data", dif.out_data, e);
        chk("dump_mux", dif.addr_mux_select, 2);
        chk("dump_addr", dif.dmem_addr, k);
        if (held == 0) chk("dump_spacing", neg - last, 3);
        if (k == stall_word && held < stall_cyc) begin
          dif.out_ready = 1'b0;
          held++;
        end else begin
          dif.out_ready = 1'b1;
          void'(exp_q.pop_front());
          last = neg;
          held = 0;
          k++;
        end
      end else if (held > 0) begin
        chk("stall_valid_held", dif.out_valid, 1);
      end
    end
    chk("dump_complete", k, ND);
    exp_q.delete();
    @(negedge clk);
    chk("done_set", dif.done, 1);
    chk("done_mux", dif.addr_mux_select, 0);
    chk("done_out_valid", dif.out_valid, 0);
    chk("done_busy", dif.busy, 1);
    chk("done_mult_held", dif.mult_cycles, exp_mult);
    @(negedge clk);
    chk("idle_busy_after", dif.busy, 0);
    chk("idle_done_held", dif.done, 1);
  endtask

  task automatic run_session(input vec_t v);
    int base;
    base = wr_count;
    do_go();
    do_load(v.ld, NL, v.gap_pct, v.spur);
    do_core(v.ld, v.res, v.lat, v.spur, v.exp_mult);
    do_dump(v.res, v.stall_word, v.stall_cyc, v.exp_mult);
    chk("write_count", wr_count - base, NL);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    dif.go        = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_data   = '0;
    dif.out_ready = 1'b0;
    dif.core_end  = 1'b0;
    core_buf      = '0;

    for (int i = 0; i < NL; i++) begin
      tbl[0].ld[i] = DW'(10 * (i + 1));
      tbl[1].ld[i] = DW'(16'h1000 + 3 * i);
      tbl[2].ld[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
    end
    for (int i = 0; i < ND; i++) begin
      tbl[0].res[i] = DW'(16'hA0 + i);
      tbl[1].res[i] = DW'(16'h5A5A ^ i);
    end
    tbl[2].res = {16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    tbl[0].lat = 7; tbl[0].exp_mult = 32'd8; tbl[0].gap_pct = 0;
    tbl[0].stall_word = ND; tbl[0].stall_cyc = 0; tbl[0].spur = 1'b0;
    tbl[1].lat = 3; tbl[1].exp_mult = 32'd4; tbl[1].gap_pct = 40;
    tbl[1].stall_word = 1; tbl[1].stall_cyc = 10; tbl[1].spur = 1'b1;
    tbl[2].lat = 1; tbl[2].exp_mult = 32'd2; tbl[2].gap_pct = 70;
    tbl[2].stall_word = 3; tbl[2].stall_cyc = 2; tbl[2].spur = 1'b0;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    for (int t = 0; t < 3; t++) run_session(tbl[t]);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NL; i++) v.ld[i] = DW'($urandom);
      for (int i = 0; i < ND; i++) v.res[i] = DW'($urandom);
      v.lat        = int'($urandom_range(1, 25));
      v.exp_mult   = 32'(v.lat + 1);
      v.gap_pct    = int'($urandom_range(0, 60));
      v.stall_word = int'($urandom_range(0, ND));
      v.stall_cyc  = int'($urandom_range(1, 6));
      v.spur       = 1'($urandom_range(0, 1));
      run_session(v);
    end

    // Reset lands between clock edges while the second word is being written.
    do_go();
    do_load(tbl[1].ld, 2, 0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    run_session(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
